// File: rtl/uart_io_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_io_pkg
// Purpose : Shared constants and types for the UART LED/switch command bridge:
//           command opcodes, reply bytes, line-ending bytes, decoder states.
// Revision: 1.0 - initial release
// ============================================================================
package uart_io_pkg;

  // Command opcodes
  localparam logic [7:0] OP_W = 8'h57;  // 'W' addr data : write LED byte
  localparam logic [7:0] OP_R = 8'h52;  // 'R' addr      : read switch byte
  localparam logic [7:0] OP_A = 8'h41;  // 'A'           : dump all switch bytes

  // Reply bytes
  localparam logic [7:0] RSP_K = 8'h4B; // write accepted
  localparam logic [7:0] RSP_E = 8'h45; // error / unknown command

  // Line endings silently skipped between commands when enabled
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DUMP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_io_bridge_txq.sv
`default_nettype none
// ============================================================================
// Module  : uart_txq
// Purpose : Byte-wide synchronous FIFO holding reply bytes for the UART
//           transmitter. Push and pop in the same cycle both take effect,
//           even when full. Pop while empty is ignored; push while full
//           without a pop is discarded (caller flags the overflow).
// Ports   : clk, rst_n     - clock, async active-low reset
//           i_push, i_din  - write request and data
//           i_pop          - remove head byte
//           o_dout         - head byte, 0x00 when empty
//           o_full/o_empty - occupancy flags
//           o_free         - number of free slots
// Revision: 1.0 - initial release
// ============================================================================
module uart_txq #(
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_din,
  input  logic          i_pop,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_free
);

  localparam logic [AW-1:0] c_PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == c_DEPTH);
  assign o_free    = c_DEPTH - r_cnt;
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the slot in the same cycle, so a full queue still accepts.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = o_empty ? 8'h00 : r_mem[r_rd];

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Storage needs no reset: o_dout is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= ptr_next(r_wr);
      if (w_do_pop)  r_rd <= ptr_next(r_rd);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_io_bridge.sv
`default_nettype none
// ============================================================================
// Module  : uart_io_bridge
// Purpose : Decodes an addressed byte protocol from a UART receiver and
//           drives LED registers / reports switch groups through a reply
//           queue feeding the UART transmitter.
//             'W' addr data -> LED byte write, reply 'K' (or 'E' if bad addr)
//             'R' addr      -> reply switch byte (or 'E' if bad addr)
//             'A'           -> reply all switch bytes, byte 0 first
// Ports   : clk, rst_n           - clock, async active-low reset
//           i_rx_vld, i_rx_data  - received byte strobe and data
//           o_tx_ready, o_tx_data- reply byte available / head byte
//           i_tx_rd              - transmitter accepted head byte
//           o_led                - LED registers, byte k = o_led[8k+7:8k]
//           i_sw                 - synchronised switch inputs
//           o_ovf                - sticky: reply or command byte dropped
//           o_busy               - decoder is mid-command or dumping
// Revision: 1.0 - initial release
// ============================================================================
module uart_io_bridge
  import uart_io_pkg::*;
#(
  parameter int LED_BYTES   = 4,
  parameter int SW_BYTES    = 4,
  parameter int TXQ_DEPTH   = 8,
  parameter int TIMEOUT_CYC = 50000000,
  parameter bit IGNORE_LF   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_rx_vld,
  input  logic [7:0]             i_rx_data,
  output logic                   o_tx_ready,
  input  logic                   i_tx_rd,
  output logic [7:0]             o_tx_data,
  output logic [8*LED_BYTES-1:0] o_led,
  input  logic [8*SW_BYTES-1:0]  i_sw,
  output logic                   o_ovf,
  output logic                   o_busy
);

  localparam int QCW = $clog2(TXQ_DEPTH + 1);
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [TW-1:0]  c_TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [QCW-1:0] c_DUMP_SLOTS = QCW'(SW_BYTES);
  localparam logic [3:0]     c_DUMP_LAST  = 4'(SW_BYTES - 1);
  localparam logic [7:0]     c_SW_N       = 8'(SW_BYTES);
  localparam logic [7:0]     c_LED_N      = 8'(LED_BYTES);

  state_t                 r_state;
  logic [7:0]             r_op;
  logic [7:0]             r_addr;
  logic [TW-1:0]          r_tmo;
  logic [3:0]             r_dump_idx;
  logic [8*SW_BYTES-1:0]  r_dump_sh;
  logic [8*LED_BYTES-1:0] r_led;
  logic                   r_ovf;

  logic           w_push;
  logic [7:0]     w_pdata;
  logic           w_full;
  logic           w_empty;
  logic [QCW-1:0] w_free;
  logic           w_drop;
  logic           w_a_ok;
  logic           w_ovf_set;
  logic [7:0]     w_sw_rd;
  logic [7:0]     w_dump_byte;

  assign o_led      = r_led;
  assign o_ovf      = r_ovf;
  assign o_busy     = (r_state != S_IDLE);
  assign o_tx_ready = ~w_empty;

  // A dump is only started when the whole reply fits, so it never drops.
  assign w_a_ok = (w_free >= c_DUMP_SLOTS);
  assign w_drop = w_push & w_full & ~(i_tx_rd & ~w_empty);

  assign w_ovf_set = w_drop
                   | ((r_state == S_IDLE) & i_rx_vld & (i_rx_data == OP_A) & ~w_a_ok)
                   | ((r_state == S_DUMP) & i_rx_vld);

  // Live switch byte addressed by the byte being received right now.
  always_comb begin
    w_sw_rd = 8'h00;
    for (int k = 0; k < SW_BYTES; k++) begin
      if (i_rx_data == 8'(k)) w_sw_rd = i_sw[8*k +: 8];
    end
  end

  always_comb begin
    w_dump_byte = 8'h00;
    for (int k = 0; k < SW_BYTES; k++) begin
      if (r_dump_idx == 4'(k)) w_dump_byte = r_dump_sh[8*k +: 8];
    end
  end

  // Reply generation: the byte is pushed in the cycle the final command
  // byte arrives, so it is visible at the queue head one clock later.
  always_comb begin
    w_push  = 1'b0;
    w_pdata = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (i_rx_vld && i_rx_data != OP_W && i_rx_data != OP_R &&
            i_rx_data != OP_A &&
            !(IGNORE_LF && (i_rx_data == CH_LF || i_rx_data == CH_CR))) begin
          w_push  = 1'b1;
          w_pdata = RSP_E;
        end
      end
      S_ADDR: begin
        if (i_rx_vld && r_op == OP_R) begin
          w_push  = 1'b1;
          w_pdata = (i_rx_data < c_SW_N) ? w_sw_rd : RSP_E;
        end
      end
      S_DATA: begin
        if (i_rx_vld) begin
          w_push  = 1'b1;
          w_pdata = (r_addr < c_LED_N) ? RSP_K : RSP_E;
        end
      end
      S_DUMP: begin
        w_push  = 1'b1;
        w_pdata = w_dump_byte;
      end
      default: begin
        w_push  = 1'b0;
        w_pdata = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= 8'h00;
      r_addr     <= 8'h00;
      r_tmo      <= '0;
      r_dump_idx <= 4'd0;
      r_dump_sh  <= '0;
      r_led      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_ovf_set) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (i_rx_vld) begin
            if (i_rx_data == OP_W || i_rx_data == OP_R) begin
              r_op    <= i_rx_data;
              r_state <= S_ADDR;
            end else if (i_rx_data == OP_A && w_a_ok) begin
              r_dump_sh  <= i_sw;
              r_dump_idx <= 4'd0;
              r_state    <= S_DUMP;
            end
          end
        end
        S_ADDR: begin
          if (i_rx_vld) begin
            r_addr  <= i_rx_data;
            r_tmo   <= '0;
            r_state <= (r_op == OP_W) ? S_DATA : S_IDLE;
          end else if (r_tmo == c_TMO_LAST) begin
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DATA: begin
          if (i_rx_vld) begin
            for (int k = 0; k < LED_BYTES; k++) begin
              if (r_addr == 8'(k)) r_led[8*k +: 8] <= i_rx_data;
            end
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else if (r_tmo == c_TMO_LAST) begin
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DUMP: begin
          if (r_dump_idx == c_DUMP_LAST) r_state <= S_IDLE;
          else                           r_dump_idx <= r_dump_idx + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  uart_txq #(
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_pdata),
    .i_pop   (i_tx_rd),
    .o_dout  (o_tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_free  (w_free)
  );

endmodule
`default_nettype wire
